// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between a serial receiver and its consumer.
// Show-ahead output, registered occupancy count and a sticky overflow flag.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rcv,
    input  logic [7:0]            data,
    input  logic                  rd,
    input  logic                  ovf_clr,
    output logic [7:0]            dout,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  ovf
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  do_write, do_read, ovf_set;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_COUNT);
    assign count = count_q;
    assign ovf   = ovf_q;
    assign dout  = empty ? 8'h00 : mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a full FIFO still accepts a write while rd is high.
    assign do_read  = rd && !empty;
    assign do_write = rcv && (!full || rd);
    assign ovf_set  = rcv && full && !rd;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (do_write) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_read)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_write, do_read})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (ovf_set)      ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is deliberately left out of reset; stale bytes are masked by the empty check on dout.
    always_ff @(posedge clk) begin
        if (do_write) mem_q[wr_ptr_q] <= data;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a queue of expected bytes is filled on accepted
// writes and popped against dout on every accepted read, alongside flag/count checks.
module tb_uart_rx_fifo;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic                clk = 1'b0;
    logic                rst;
    logic                rcv;
    logic [7:0]          data;
    logic                rd;
    logic                ovf_clr;
    logic [7:0]          dout;
    logic                empty;
    logic                full;
    logic [DEPTH_LOG2:0] count;
    logic                ovf;

    logic [7:0] expQ [$];
    logic       mOvf;
    int         nChecks = 0;
    int         nFails  = 0;

    uart_rx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk     (clk),
        .rst     (rst),
        .rcv     (rcv),
        .data    (data),
        .rd      (rd),
        .ovf_clr (ovf_clr),
        .dout    (dout),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compares every output against the reference model state.
    task automatic checkOutput(input string tag);
        logic [7:0] expDout;
        expDout = (expQ.size() == 0) ? 8'h00 : expQ[0];
        checkEq({tag, ".dout"},  32'(dout),  32'(expDout));
        checkEq({tag, ".count"}, 32'(count), 32'(expQ.size()));
        checkEq({tag, ".empty"}, 32'(empty), 32'(expQ.size() == 0));
        checkEq({tag, ".full"},  32'(full),  32'(expQ.size() == DEPTH));
        checkEq({tag, ".ovf"},   32'(ovf),   32'(mOvf));
    endtask

    // Drives one cycle of inputs, checks outputs mid-cycle, then advances the model on the edge.
    task automatic applyStimulus(input logic rcvV, input logic [7:0] dataV,
                                 input logic rdV, input logic clrV, input string tag);
        logic mFull, mEmpty;
        rcv = rcvV; data = dataV; rd = rdV; ovf_clr = clrV;
        @(negedge clk);
        checkOutput(tag);
        mFull  = (expQ.size() == DEPTH);
        mEmpty = (expQ.size() == 0);
        if (rdV && !mEmpty) begin
            checkEq({tag, ".pop"}, 32'(dout), 32'(expQ[0]));
            void'(expQ.pop_front());
        end
        if (rcvV && (!mFull || rdV)) expQ.push_back(dataV);
        if (rcvV && mFull && !rdV) mOvf = 1'b1;
        else if (clrV)             mOvf = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rcv = 1'b0; data = 8'h00; rd = 1'b0; ovf_clr = 1'b0;
        mOvf = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset then idle, with noise on data and an underflow read.
        applyStimulus(1'b0, 8'h5A, 1'b0, 1'b0, "idle");
        applyStimulus(1'b0, 8'hFF, 1'b1, 1'b0, "underflow");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, "idle2");

        // Basic ordering.
        applyStimulus(1'b1, 8'h41, 1'b0, 1'b0, "wrA");
        applyStimulus(1'b1, 8'h42, 1'b0, 1'b0, "wrB");
        applyStimulus(1'b1, 8'h43, 1'b0, 1'b0, "wrC");
        applyStimulus(1'b0, 8'h99, 1'b1, 1'b0, "rdA");
        applyStimulus(1'b0, 8'h99, 1'b1, 1'b0, "rdB");
        applyStimulus(1'b0, 8'h99, 1'b1, 1'b0, "rdC");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, "drained");

        // Fill to full, overflow on the 17th byte, drain, then clear ovf.
        for (int i = 0; i <= DEPTH; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, "fill");
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1, "ovfSetWins");
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "drain");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, "ovfClr");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, "ovfCleared");

        // Full with simultaneous write and read.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, "fill2");
        applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0, "fullWrRd");
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "drain2");

        // Empty with simultaneous write and read: write only.
        applyStimulus(1'b1, 8'h11, 1'b1, 1'b0, "emptyWrRd");

        // Steady state at count=1 across pointer wrap.
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, 8'(8'h80 + i), 1'b1, 1'b0, "wrap");
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "wrapDrain");

        // Asynchronous reset between edges.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, "preRst");
        rcv = 1'b0; rd = 1'b0; ovf_clr = 1'b0;
        #2 rst = 1'b1;
        #1;
        expQ.delete();
        mOvf = 1'b0;
        checkOutput("asyncRst");
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, "postRstWr");
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "postRstRd");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, "final");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
